// File: rtl/sensor_pkg.sv
// ============================================================================
// Module      : sensor_pkg
// Description : Shared state encoding and default constants for the sensor
//               alarm controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sensor_pkg;

   localparam int DEFAULT_DEBOUNCE  = 4;
   localparam int DEFAULT_CNT_WIDTH = 8;

   // Debounce lengths of 1..15 fit in four bits.
   localparam int DBNC_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_QUALIFY    = 2'd1,
      ST_ALARM      = 2'd2,
      ST_WAIT_CLEAR = 2'd3
   } alarm_state_t;

endpackage : sensor_pkg

`default_nettype wire

// File: rtl/sensor_debounce_cnt.sv
// ============================================================================
// Module      : sensor_debounce_cnt
// Description : Consecutive-sample debounce counter with synchronous clear,
//               enable and terminal-count flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sensor_debounce_cnt
   import sensor_pkg::*;
#(
   parameter int TERMINAL = DEFAULT_DEBOUNCE
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [DBNC_WIDTH-1:0] LAST = DBNC_WIDTH'(TERMINAL - 1);
   localparam logic [DBNC_WIDTH-1:0] ONE  = DBNC_WIDTH'(1);

   logic [DBNC_WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + ONE;
      end
   end

   // High when one more high sample completes qualification; with a
   // terminal of 1 this is already true from the cleared state.
   assign tc_o = (count_q == LAST);

endmodule : sensor_debounce_cnt

`default_nettype wire

// File: rtl/sensor_alarm_ctrl.sv
// ============================================================================
// Module      : sensor_alarm_ctrl
// Description : Debounced sensor fault alarm with snapshot, acknowledge and
//               saturating qualified-event counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sensor_alarm_ctrl
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
   parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 error,
   input  logic [3:0]           sensors,
   input  logic                 ack,
   output logic                 alarm,
   output logic [3:0]           alarm_code,
   output logic [CNT_WIDTH-1:0] event_count,
   output logic                 busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   alarm_state_t         state_q;
   logic                 alarm_q;
   logic                 busy_q;
   logic [3:0]           code_q;
   logic [CNT_WIDTH-1:0] evcnt_q;

   logic dbnc_en;
   logic dbnc_clr;
   logic dbnc_tc;

   // The counter only advances on high samples while qualifying and is
   // cleared on every other edge, including the one that enters ALARM.
   always_comb begin
      dbnc_en  = ((state_q == ST_IDLE) || (state_q == ST_QUALIFY)) && error && !dbnc_tc;
      dbnc_clr = !dbnc_en;
   end

   sensor_debounce_cnt #(
      .TERMINAL (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .clr_i (dbnc_clr),
      .en_i  (dbnc_en),
      .tc_o  (dbnc_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         alarm_q <= 1'b0;
         busy_q  <= 1'b0;
         code_q  <= 4'b0000;
         evcnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_QUALIFY: begin
               if (!error) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (dbnc_tc) begin
                  state_q <= ST_ALARM;
                  alarm_q <= 1'b1;
                  busy_q  <= 1'b1;
                  code_q  <= sensors;
                  if (evcnt_q != '1) begin
                     evcnt_q <= evcnt_q + CNT_ONE;
                  end
               end else begin
                  state_q <= ST_QUALIFY;
                  busy_q  <= 1'b1;
               end
            end
            ST_ALARM: begin
               if (ack) begin
                  alarm_q <= 1'b0;
                  if (error) begin
                     state_q <= ST_WAIT_CLEAR;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            ST_WAIT_CLEAR: begin
               // A fault still present after acknowledge must drop before
               // it can qualify again.
               if (!error) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               alarm_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign alarm       = alarm_q;
   assign alarm_code  = code_q;
   assign event_count = evcnt_q;
   assign busy        = busy_q;

endmodule : sensor_alarm_ctrl

`default_nettype wire

// File: tb/tb_sensor_alarm_ctrl.sv
// ============================================================================
// Module      : tb_sensor_alarm_ctrl
// Description : Scoreboard bench for sensor_alarm_ctrl, three configurations
//               sharing one stimulus stream against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sensor_alarm_ctrl;

   typedef struct {
      int run;
      bit alm;
      bit stuck;
      int code;
      int cnt;
   } mdl_t;

   typedef struct {
      bit alm;
      int code;
      int cnt;
      bit busy;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       error;
   logic       ack;
   logic [3:0] sensors;

   logic       alarm0, alarm1, alarm2;
   logic [3:0] code0, code1, code2;
   logic [7:0] cnt0, cnt2;
   logic [1:0] cnt1;
   logic       busy0, busy1, busy2;

   int   n_tests = 0;
   int   n_fail  = 0;
   bit   done    = 0;

   mdl_t m [3];
   int   dcy [3] = '{4, 4, 1};
   int   cmx [3] = '{255, 3, 255};
   exp_t q0 [$];
   exp_t q1 [$];
   exp_t q2 [$];

   sensor_alarm_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) u_dut0 (
      .clk(clk), .rst(rst), .error(error), .sensors(sensors), .ack(ack),
      .alarm(alarm0), .alarm_code(code0), .event_count(cnt0), .busy(busy0));

   sensor_alarm_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(2)) u_dut1 (
      .clk(clk), .rst(rst), .error(error), .sensors(sensors), .ack(ack),
      .alarm(alarm1), .alarm_code(code1), .event_count(cnt1), .busy(busy1));

   sensor_alarm_ctrl #(.DEBOUNCE_CYCLES(1), .CNT_WIDTH(8)) u_dut2 (
      .clk(clk), .rst(rst), .error(error), .sensors(sensors), .ack(ack),
      .alarm(alarm2), .alarm_code(code2), .event_count(cnt2), .busy(busy2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: run = consecutive high error samples while armed; stuck = fault
   // acknowledged but not yet cleared.
   function automatic mdl_t step(mdl_t s, int d, int mx, bit r, bit e, bit a, int sens);
      mdl_t n;
      n = s;
      if (r) begin
         n.run = 0; n.alm = 0; n.stuck = 0; n.code = 0; n.cnt = 0;
      end else if (s.alm) begin
         if (a) begin
            n.alm   = 0;
            n.stuck = e;
         end
      end else if (s.stuck) begin
         if (!e) n.stuck = 0;
      end else if (e) begin
         n.run = s.run + 1;
         if (n.run >= d) begin
            n.run  = 0;
            n.alm  = 1;
            n.code = sens;
            if (s.cnt < mx) n.cnt = s.cnt + 1;
         end
      end else begin
         n.run = 0;
      end
      return n;
   endfunction

   function automatic exp_t expect_of(mdl_t s);
      exp_t x;
      x.alm  = s.alm;
      x.code = s.code;
      x.cnt  = s.cnt;
      x.busy = s.alm || s.stuck || (s.run > 0);
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input int exp_v);
      n_tests++;
      if (act !== 32'(exp_v)) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit a, input int s);
      @(negedge clk);
      rst     = r;
      error   = e;
      ack     = a;
      sensors = 4'(s);
      for (int i = 0; i < 3; i++) m[i] = step(m[i], dcy[i], cmx[i], r, e, a, s & 15);
      q0.push_back(expect_of(m[0]));
      q1.push_back(expect_of(m[1]));
      q2.push_back(expect_of(m[2]));
   endtask

   task automatic qualify(input int n, input int s);
      repeat (n) cyc(0, 1, 0, s);
   endtask

   // Monitor: one expected entry per driven edge, compared just after it.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk);
         #1;
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("d0.alarm", alarm0, e.alm);
            chk("d0.alarm_code", code0, e.code);
            chk("d0.event_count", cnt0, e.cnt);
            chk("d0.busy", busy0, e.busy);
         end
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("d1.alarm", alarm1, e.alm);
            chk("d1.alarm_code", code1, e.code);
            chk("d1.event_count", cnt1, e.cnt);
            chk("d1.busy", busy1, e.busy);
         end
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("d2.alarm", alarm2, e.alm);
            chk("d2.alarm_code", code2, e.code);
            chk("d2.event_count", cnt2, e.cnt);
            chk("d2.busy", busy2, e.busy);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; error = 1'b0; ack = 1'b0; sensors = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         m[i].run = 0; m[i].alm = 0; m[i].stuck = 0; m[i].code = 0; m[i].cnt = 0;
      end

      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);

      // Qualified alarm with snapshot 0110; later sensor changes ignored.
      qualify(4, 4'b0110);
      cyc(0, 1, 0, 9);
      cyc(0, 0, 0, 15);
      cyc(0, 0, 1, 3);
      cyc(0, 0, 0, 0);

      // Three highs then a low: no alarm.
      qualify(3, 5);
      cyc(0, 0, 0, 5);
      cyc(0, 0, 0, 0);

      // Stuck fault: ack with error high, held 20 cycles, only one alarm.
      qualify(4, 10);
      cyc(0, 1, 1, 0);
      for (int k = 0; k < 19; k++) cyc(0, 1, (k % 5) == 0, k);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);

      // Repeated alarms drive the narrow counter into saturation.
      for (int k = 0; k < 5; k++) begin
         qualify(4, k + 1);
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 0);
      end

      // Reset mid-qualify and in alarm; full requalification afterwards.
      qualify(2, 1);
      cyc(1, 1, 0, 1);
      qualify(4, 7);
      cyc(0, 0, 1, 0);
      qualify(4, 2);
      cyc(1, 1, 0, 2);
      qualify(4, 3);
      cyc(0, 0, 1, 0);

      // Single-cycle pulse with ack held through alarm entry.
      cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 12);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);

      // Ack-to-idle immediately followed by a new fault.
      qualify(4, 8);
      cyc(0, 0, 1, 0);
      qualify(4, 4);
      cyc(0, 0, 1, 0);

      for (int k = 0; k < 600; k++) begin
         cyc($urandom_range(0, 63) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) == 0,
             int'($urandom_range(0, 15)));
      end

      cyc(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      done = 1;
      n_tests++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0",
                  q0.size() + q1.size() + q2.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_sensor_alarm_ctrl

`default_nettype wire
